// File: rtl/prim_arbiter_wrr_burst.sv
// -----------------------------------------------------------------------------
// prim_arbiter_wrr_burst
//   Weighted round-robin arbiter with burst lock. N requesters share one
//   downstream valid/ready port. A granted burst is never interleaved with
//   another requester's beats. Each requester may send up to its weight in
//   bursts back-to-back before priority rotates to the next index.
//
//   Optional feature macro: PRIM_ARB_WRR_WEIGHT_EN
//     defined     : weighted round-robin (weight_i bursts per turn, 0 -> 1)
//     not defined : plain round-robin at burst granularity, weight_i unused
//
// Ports
//   clk_i     in   1     clock
//   rst_i     in   1     asynchronous active-high reset
//   req_i     in   N     per-requester beat valid, held until granted
//   last_i    in   N     per-requester end-of-burst flag
//   data_i    in   N*DW  per-requester payload, requester i at [i*DW +: DW]
//   weight_i  in   N*WW  bursts per turn, requester i at [i*WW +: WW]
//   gnt_o     out  N     one-hot beat accept for the winner
//   valid_o   out  1     downstream beat valid
//   data_o    out  DW    winner payload (0 when idle)
//   last_o    out  1     winner end-of-burst flag (0 when idle)
//   idx_o     out  IdxW  winner index (0 when idle)
//   ready_i   in   1     downstream ready
//
// Outputs are a zero-cycle combinational pass-through of state and inputs.
// -----------------------------------------------------------------------------
module prim_arbiter_wrr_burst #(
    parameter  int unsigned N    = 4,
    parameter  int unsigned DW   = 32,
    parameter  int unsigned WW   = 4,
    localparam int unsigned IdxW = $clog2(N)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [N-1:0]      req_i,
    input  logic [N-1:0]      last_i,
    input  logic [N*DW-1:0]   data_i,
    input  logic [N*WW-1:0]   weight_i,
    output logic [N-1:0]      gnt_o,
    output logic              valid_o,
    output logic [DW-1:0]     data_o,
    output logic              last_o,
    output logic [IdxW-1:0]   idx_o,
    input  logic              ready_i
);

    // ST_LOCK: a burst is open (or a beat is stalled) and owner_q holds the port
    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   owner_q, owner_d;
    logic [IdxW-1:0]   ptr_q,   ptr_d;
    logic [WW-1:0]     credit_q, credit_d;

    logic [IdxW-1:0]   scan_cand;
    logic [IdxW-1:0]   scan_idx;
    logic [IdxW-1:0]   win_idx;
    logic [IdxW-1:0]   win_next;
    logic              sel_req;
    logic              sel_last;
    logic [DW-1:0]     sel_data;
    logic              valid;
    logic              hs;
    logic              burst_end;
    logic [WW-1:0]     cur;
    logic [WW-1:0]     cur_m1;

`ifdef PRIM_ARB_WRR_WEIGHT_EN
    logic [WW-1:0]     sel_weight;
`else
    // Weights and credit have no effect in plain round-robin mode
    logic              unused_cfg;
    assign unused_cfg = ^{weight_i, credit_q};
`endif

    // Rotating priority scan: walking from the far end down to ptr_q means the
    // last assignment is the first requester at or after ptr_q.
    always_comb begin
        scan_idx  = ptr_q;
        scan_cand = '0;
        for (int k = int'(N) - 1; k >= 0; k--) begin
            scan_cand = IdxW'((32'(ptr_q) + 32'(k)) % N);
            if (req_i[scan_cand]) begin
                scan_idx = scan_cand;
            end
        end
    end

    // While locked, all other requests are ignored
    assign win_idx = (state_q == ST_LOCK) ? owner_q : scan_idx;

    // Winner payload mux
    always_comb begin
        sel_req  = 1'b0;
        sel_last = 1'b0;
        sel_data = '0;
`ifdef PRIM_ARB_WRR_WEIGHT_EN
        sel_weight = '0;
`endif
        for (int i = 0; i < int'(N); i++) begin
            if (win_idx == IdxW'(i)) begin
                sel_req  = req_i[i];
                sel_last = last_i[i];
                sel_data = data_i[i*DW +: DW];
`ifdef PRIM_ARB_WRR_WEIGHT_EN
                sel_weight = weight_i[i*WW +: WW];
`endif
            end
        end
    end

    // Downstream outputs; nothing is offered while reset is asserted
    always_comb begin
        valid     = sel_req & ~rst_i;
        hs        = valid & ready_i;
        burst_end = hs & sel_last;

        valid_o = valid;
        data_o  = valid ? sel_data : '0;
        last_o  = valid & sel_last;
        idx_o   = valid ? win_idx : '0;

        gnt_o = '0;
        for (int i = 0; i < int'(N); i++) begin
            gnt_o[i] = hs && (win_idx == IdxW'(i));
        end
    end

    // Lock FSM: a stall or an unfinished burst pins the winner
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        unique case (state_q)
            ST_ARB: begin
                if (valid && !burst_end) begin
                    state_d = ST_LOCK;
                    owner_d = win_idx;
                end
            end
            ST_LOCK: begin
                // A dropped owner request leaves valid low and the lock in place
                if (burst_end) begin
                    state_d = ST_ARB;
                end
            end
            default: state_d = ST_ARB;
        endcase
    end

    assign win_next = (win_idx == IdxW'(N - 1)) ? '0 : win_idx + IdxW'(1);

    // Credit and pointer update, only at a burst end
    always_comb begin
`ifdef PRIM_ARB_WRR_WEIGHT_EN
        // Remaining credit only applies to the requester that earned it;
        // anyone else (a skip past an idle ptr_q) starts from a fresh weight.
        if ((win_idx == ptr_q) && (credit_q != '0)) begin
            cur = credit_q;
        end else if (sel_weight == '0) begin
            cur = WW'(1);
        end else begin
            cur = sel_weight;
        end
`else
        cur = WW'(1);
`endif
        cur_m1   = cur - WW'(1);
        ptr_d    = ptr_q;
        credit_d = credit_q;
        if (burst_end) begin
            if (cur_m1 == '0) begin
                ptr_d    = win_next;
                credit_d = '0;
            end else begin
                ptr_d    = win_idx;
                credit_d = cur_m1;
            end
        end
    end

    // State registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_ARB;
            owner_q  <= '0;
            ptr_q    <= '0;
            credit_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            ptr_q    <= ptr_d;
            credit_q <= credit_d;
        end
    end

    // The lock owner must keep requesting until its burst ends
    a_owner_holds_req: assert property (
        @(posedge clk_i) disable iff (rst_i)
        (state_q == ST_LOCK) |-> req_i[owner_q]
    ) else $error("prim_arbiter_wrr_burst: owner %0d dropped req_i while locked", owner_q);

endmodule

// File: tb/tb_prim_arbiter_wrr_burst.sv
// -----------------------------------------------------------------------------
// Directed testbench for prim_arbiter_wrr_burst (N=4, DW=32, WW=4).
// Inputs change 1 time unit after a rising edge; outputs are sampled 1 time
// unit later, well clear of the next edge.
// -----------------------------------------------------------------------------
module tb_prim_arbiter_wrr_burst;

    localparam int unsigned N    = 4;
    localparam int unsigned DW   = 32;
    localparam int unsigned WW   = 4;
    localparam int unsigned IdxW = 2;

    // weights [w0,w1,w2,w3] = [1,2,1,3]
    localparam logic [N*WW-1:0] W_DEF = {4'd3, 4'd1, 4'd2, 4'd1};
    localparam logic [N*WW-1:0] W_ONE = {4'd1, 4'd1, 4'd1, 4'd1};

    logic              clk_i;
    logic              rst_i;
    logic [N-1:0]      req_i;
    logic [N-1:0]      last_i;
    logic [N*DW-1:0]   data_i;
    logic [N*WW-1:0]   weight_i;
    logic [N-1:0]      gnt_o;
    logic              valid_o;
    logic [DW-1:0]     data_o;
    logic              last_o;
    logic [IdxW-1:0]   idx_o;
    logic              ready_i;

    logic [DW-1:0]     d [N];
    logic [N-1:0]      exp_order [8];

    int checks   = 0;
    int failures = 0;

    prim_arbiter_wrr_burst #(
        .N  (N),
        .DW (DW),
        .WW (WW)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .req_i    (req_i),
        .last_i   (last_i),
        .data_i   (data_i),
        .weight_i (weight_i),
        .gnt_o    (gnt_o),
        .valid_o  (valid_o),
        .data_o   (data_o),
        .last_o   (last_o),
        .idx_o    (idx_o),
        .ready_i  (ready_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    always_comb begin
        for (int i = 0; i < int'(N); i++) begin
            data_i[i*DW +: DW] = d[i];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic apply_reset();
        rst_i  = 1'b1;
        req_i  = '0;
        last_i = '0;
        next_cycle();
        rst_i  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_i    = 1'b1;
        req_i    = '0;
        last_i   = '0;
        ready_i  = 1'b0;
        weight_i = W_DEF;
        for (int i = 0; i < int'(N); i++) d[i] = '0;

`ifdef PRIM_ARB_WRR_WEIGHT_EN
        exp_order = '{4'b0001, 4'b0010, 4'b0010, 4'b0100,
                      4'b1000, 4'b1000, 4'b1000, 4'b0001};
`else
        exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                      4'b0001, 4'b0010, 4'b0100, 4'b1000};
`endif

        // 1: reset holds everything at 0 even with all requests up
        req_i   = 4'b1111;
        last_i  = 4'b1111;
        ready_i = 1'b1;
        for (int i = 0; i < int'(N); i++) d[i] = 32'hA0 + 32'(i);
        #2;
        chk("t1_rst_gnt",   32'(gnt_o),   32'h0);
        chk("t1_rst_valid", 32'(valid_o), 32'h0);
        chk("t1_rst_idx",   32'(idx_o),   32'h0);
        chk("t1_rst_data",  data_o,       32'h0);
        chk("t1_rst_last",  32'(last_o),  32'h0);
        next_cycle();
        rst_i = 1'b0;
        settle();
        chk("t1_gnt",  32'(gnt_o), 32'h1);
        chk("t1_data", data_o,     32'hA0);
        next_cycle();
        req_i = '0;
        settle();
        chk("t1_idle_valid", 32'(valid_o), 32'h0);
        chk("t1_idle_gnt",   32'(gnt_o),   32'h0);
        chk("t1_idle_data",  data_o,       32'h0);

        // 2: 3-beat burst from req0, req1 arrives on beat 2 and waits
        apply_reset();
        d[0]   = 32'hB1;
        req_i  = 4'b0001;
        last_i = 4'b0000;
        settle();
        chk("t2_b1_gnt",  32'(gnt_o),  32'h1);
        chk("t2_b1_data", data_o,      32'hB1);
        chk("t2_b1_last", 32'(last_o), 32'h0);
        next_cycle();
        d[0]   = 32'hB2;
        d[1]   = 32'hC1;
        req_i  = 4'b0011;
        last_i = 4'b0010;
        settle();
        chk("t2_b2_gnt",  32'(gnt_o), 32'h1);
        chk("t2_b2_idx",  32'(idx_o), 32'h0);
        chk("t2_b2_data", data_o,     32'hB2);
        next_cycle();
        d[0]   = 32'hB3;
        last_i = 4'b0011;
        settle();
        chk("t2_b3_gnt",  32'(gnt_o),  32'h1);
        chk("t2_b3_last", 32'(last_o), 32'h1);
        chk("t2_b3_data", data_o,      32'hB3);
        next_cycle();
        req_i = 4'b0010;
        settle();
        chk("t2_r1_gnt",  32'(gnt_o), 32'h2);
        chk("t2_r1_idx",  32'(idx_o), 32'h1);
        chk("t2_r1_data", data_o,     32'hC1);
        next_cycle();
        req_i = '0;

        // 3: req2 stalled for 5 cycles; req0 arriving mid-stall must not steal
        apply_reset();
        d[0]    = 32'h55;
        d[2]    = 32'hC2;
        req_i   = 4'b0100;
        last_i  = 4'b0101;
        ready_i = 1'b0;
        settle();
        chk("t3_s1_gnt",   32'(gnt_o),   32'h0);
        chk("t3_s1_valid", 32'(valid_o), 32'h1);
        chk("t3_s1_idx",   32'(idx_o),   32'h2);
        chk("t3_s1_data",  data_o,       32'hC2);
        for (int c = 2; c <= 5; c++) begin
            next_cycle();
            req_i = 4'b0101;
            settle();
            chk("t3_stall_idx",  32'(idx_o), 32'h2);
            chk("t3_stall_data", data_o,     32'hC2);
            chk("t3_stall_gnt",  32'(gnt_o), 32'h0);
        end
        next_cycle();
        ready_i = 1'b1;
        settle();
        chk("t3_ready_gnt", 32'(gnt_o), 32'h4);
        next_cycle();
        req_i = 4'b0001;
        settle();
        chk("t3_after_gnt", 32'(gnt_o), 32'h1);
        next_cycle();
        req_i = '0;

        // 4: all requesters, single-beat bursts, weights [1,2,1,3]
        apply_reset();
        weight_i = W_DEF;
        req_i    = 4'b1111;
        last_i   = 4'b1111;
        settle();
        for (int k = 0; k < 8; k++) begin
            chk("t4_order_gnt", 32'(gnt_o), 32'(exp_order[k]));
            next_cycle();
            settle();
        end
        req_i = '0;

        // 5: ptr at 3, only req1 requesting -> wrap past 3,0; ptr then at 2
        apply_reset();
        weight_i = W_ONE;
        req_i    = 4'b0100;
        last_i   = 4'b0100;
        settle();
        chk("t5_pre_gnt", 32'(gnt_o), 32'h4);
        next_cycle();
        req_i  = 4'b0010;
        last_i = 4'b0010;
        settle();
        chk("t5_wrap_idx", 32'(idx_o), 32'h1);
        chk("t5_wrap_gnt", 32'(gnt_o), 32'h2);
        next_cycle();
        req_i  = 4'b1111;
        last_i = 4'b1111;
        settle();
        chk("t5_ptr_idx", 32'(idx_o), 32'h2);
        next_cycle();
        req_i = '0;

        // 6: reset on beat 2 of a req3 burst; arbitration restarts at index 0
        apply_reset();
        weight_i = W_DEF;
        req_i    = 4'b0100;
        last_i   = 4'b0100;
        settle();
        chk("t6_pre_gnt", 32'(gnt_o), 32'h4);
        next_cycle();
        d[3]   = 32'hD1;
        req_i  = 4'b1001;
        last_i = 4'b0000;
        settle();
        chk("t6_b1_gnt",  32'(gnt_o), 32'h8);
        chk("t6_b1_data", data_o,     32'hD1);
        next_cycle();
        d[3] = 32'hD2;
        settle();
        chk("t6_b2_gnt", 32'(gnt_o), 32'h8);
        rst_i = 1'b1;
        settle();
        chk("t6_rst_valid", 32'(valid_o), 32'h0);
        chk("t6_rst_gnt",   32'(gnt_o),   32'h0);
        next_cycle();
        rst_i = 1'b0;
        settle();
        chk("t6_post_gnt", 32'(gnt_o), 32'h1);
        chk("t6_post_idx", 32'(idx_o), 32'h0);
        next_cycle();
        req_i = '0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
